// File: rtl/data_mem_arbiter_if.sv
// data_mem_arbiter_if: one requester's request/response channel into the data memory arbiter.
interface data_mem_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              valid;
    logic              ready;
    logic              write;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output valid, write, address, wdata,
        input  ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  valid, write, address, wdata,
        output ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: round-robin two-requester arbiter and 3-cycle sequencer for the synchronous data memory.
module data_mem_arbiter #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8,
    parameter int MEM_DEPTH = 128
) (
    input  logic              clock,
    input  logic              reset,
    data_mem_arbiter_if.slave p0,
    data_mem_arbiter_if.slave p1,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data_in,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_data_out,
    output logic              busy
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ISSUE   = 2'd1;
    localparam logic [1:0] CAPTURE = 2'd2;

    logic [1:0]        state;
    logic              last_grant;
    logic              port;
    logic              lat_write;
    logic              lat_in_range;
    logic              grant;
    logic              accept;
    logic              acc_write;
    logic              acc_in_range;
    logic [ADDR_W-1:0] acc_address;
    logic [DATA_W-1:0] acc_wdata;
    logic [DATA_W-1:0] rdata;

    // on a tie the port that did not win last time is granted
    assign grant        = (p0.valid && p1.valid) ? ~last_grant : p1.valid;
    assign p0.ready     = (state == IDLE) && p0.valid && !grant;
    assign p1.ready     = (state == IDLE) && p1.valid && grant;
    assign accept       = p0.ready || p1.ready;
    assign acc_write    = grant ? p1.write : p0.write;
    assign acc_address  = grant ? p1.address : p0.address;
    assign acc_wdata    = grant ? p1.wdata : p0.wdata;
    assign acc_in_range = {1'b0, acc_address} < (ADDR_W + 1)'(MEM_DEPTH);
    assign rdata        = (!lat_write && lat_in_range) ? mem_data_out : '0;
    assign busy         = state != IDLE;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state        <= IDLE;
            last_grant   <= 1'b1;
            port         <= 1'b0;
            lat_write    <= 1'b0;
            lat_in_range <= 1'b0;
            mem_address  <= '0;
            mem_data_in  <= '0;
            mem_write    <= 1'b0;
            p0.rsp_valid <= 1'b0;
            p0.rsp_rdata <= '0;
            p0.rsp_err   <= 1'b0;
            p1.rsp_valid <= 1'b0;
            p1.rsp_rdata <= '0;
            p1.rsp_err   <= 1'b0;
        end else begin
            p0.rsp_valid <= 1'b0;
            p1.rsp_valid <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    port         <= grant;
                    last_grant   <= grant;
                    lat_write    <= acc_write;
                    lat_in_range <= acc_in_range;
                    mem_address  <= acc_address;
                    mem_data_in  <= acc_wdata;
                    // out-of-range stores never strobe the memory
                    mem_write    <= acc_write && acc_in_range;
                    state        <= ISSUE;
                end
                ISSUE: begin
                    mem_write <= 1'b0;
                    state     <= CAPTURE;
                end
                CAPTURE: begin
                    if (port) begin
                        p1.rsp_valid <= 1'b1;
                        p1.rsp_rdata <= rdata;
                        p1.rsp_err   <= !lat_in_range;
                    end else begin
                        p0.rsp_valid <= 1'b1;
                        p0.rsp_rdata <= rdata;
                        p0.rsp_err   <= !lat_in_range;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: directed and randomized requests checked against a transaction-level arbiter/memory model.
module tb_data_mem_arbiter;
    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    data_mem_arbiter_if #(.ADDR_W(8), .DATA_W(8)) p0_bus ();
    data_mem_arbiter_if #(.ADDR_W(8), .DATA_W(8)) p1_bus ();

    logic [7:0] mem_address;
    logic [7:0] mem_data_in;
    logic [7:0] mem_data_out;
    logic       mem_write;
    logic       busy;

    data_mem_arbiter #(.ADDR_W(8), .DATA_W(8), .MEM_DEPTH(128)) dut (
        .clock(clock), .reset(reset), .p0(p0_bus), .p1(p1_bus),
        .mem_address(mem_address), .mem_data_in(mem_data_in), .mem_write(mem_write),
        .mem_data_out(mem_data_out), .busy(busy)
    );

    // synchronous 128x8 memory
    logic [7:0] mem [0:127] = '{default: 8'h00};
    always @(posedge clock) begin
        if (mem_write) mem[mem_address[6:0]] <= mem_data_in;
        mem_data_out <= mem[mem_address[6:0]];
    end

    logic       v [2];
    logic       wr [2];
    logic [7:0] ad [2];
    logic [7:0] wd [2];
    logic       rdy [2];
    logic       rv [2];
    logic       re [2];
    logic [7:0] rd [2];

    assign p0_bus.valid = v[0];
    assign p0_bus.write = wr[0];
    assign p0_bus.address = ad[0];
    assign p0_bus.wdata = wd[0];
    assign p1_bus.valid = v[1];
    assign p1_bus.write = wr[1];
    assign p1_bus.address = ad[1];
    assign p1_bus.wdata = wd[1];
    assign rdy[0] = p0_bus.ready;
    assign rdy[1] = p1_bus.ready;
    assign rv[0] = p0_bus.rsp_valid;
    assign rv[1] = p1_bus.rsp_valid;
    assign re[0] = p0_bus.rsp_err;
    assign re[1] = p1_bus.rsp_err;
    assign rd[0] = p0_bus.rsp_rdata;
    assign rd[1] = p1_bus.rsp_rdata;

    typedef struct {
        logic       w;
        logic [7:0] a;
        logic [7:0] d;
    } req_t;

    req_t q [2][$];
    int   log_p [$];
    int   log_c [$];

    int         checks = 0;
    int         failures = 0;
    bit         chk_en = 0;
    bit         gap_en = 0;
    int         cyc = 0;
    int         free_at;
    int         acc_cyc;
    int         wr_cyc;
    int         due [2];
    logic       last;
    logic [7:0] ref_mem [0:127] = '{default: 8'h00};
    logic [7:0] exp_maddr;
    logic [7:0] exp_mdin;
    logic [7:0] exp_rd [2];
    logic [7:0] pend_rd [2];
    logic       exp_err [2];
    logic       pend_err [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        last = 1'b1;
        free_at = cyc;
        acc_cyc = -100;
        wr_cyc = -100;
        exp_maddr = 8'h00;
        exp_mdin = 8'h00;
        for (int i = 0; i < 2; i++) begin
            due[i] = -100;
            exp_rd[i] = 8'h00;
            exp_err[i] = 1'b0;
        end
    endtask

    // one clock cycle: present requests, check outputs against the model, advance the model
    task automatic step();
        int   g;
        bit   rst_now;
        bit   in;
        req_t r;
        for (int i = 0; i < 2; i++) begin
            if (gap_en && v[i] && $urandom_range(7, 0) == 0) begin
                r.w = wr[i];
                r.a = ad[i];
                r.d = wd[i];
                q[i].push_front(r);
                v[i] = 1'b0;
            end else if (!v[i] && q[i].size() > 0 && !(gap_en && $urandom_range(2, 0) == 0)) begin
                r = q[i].pop_front();
                v[i] = 1'b1;
                wr[i] = r.w;
                ad[i] = r.a;
                wd[i] = r.d;
            end
        end
        #1;
        g = -1;
        if (cyc >= free_at && (v[0] || v[1]))
            g = (v[0] && v[1]) ? (last ? 0 : 1) : (v[1] ? 1 : 0);
        if (chk_en) begin
            chk("p0_ready", 32'(rdy[0]), 32'(g == 0));
            chk("p1_ready", 32'(rdy[1]), 32'(g == 1));
            chk("busy", 32'(busy), 32'(cyc == acc_cyc + 1 || cyc == acc_cyc + 2));
            chk("mem_write", 32'(mem_write), 32'(cyc == wr_cyc));
            chk("mem_address", 32'(mem_address), 32'(exp_maddr));
            chk("mem_data_in", 32'(mem_data_in), 32'(exp_mdin));
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("p%0d_rsp_valid", i), 32'(rv[i]), 32'(cyc == due[i]));
                chk($sformatf("p%0d_rsp_rdata", i), 32'(rd[i]), 32'(exp_rd[i]));
                chk($sformatf("p%0d_rsp_err", i), 32'(re[i]), 32'(exp_err[i]));
            end
        end
        if (!reset) g = -1;
        if (g >= 0) begin
            in = ad[g] < 8'd128;
            last = g[0];
            acc_cyc = cyc;
            free_at = cyc + 3;
            exp_maddr = ad[g];
            exp_mdin = wd[g];
            wr_cyc = (wr[g] && in) ? cyc + 1 : -100;
            pend_rd[g] = (!wr[g] && in) ? ref_mem[ad[g][6:0]] : 8'h00;
            pend_err[g] = !in;
            due[g] = cyc + 3;
            if (wr[g] && in) ref_mem[ad[g][6:0]] = wd[g];
            log_p.push_back(g);
            log_c.push_back(cyc);
        end
        rst_now = !reset;
        @(posedge clock);
        #1;
        cyc++;
        if (g >= 0) v[g] = 1'b0;
        if (rst_now) model_reset();
        for (int i = 0; i < 2; i++)
            if (cyc == due[i]) begin
                exp_rd[i] = pend_rd[i];
                exp_err[i] = pend_err[i];
            end
    endtask

    task automatic drain(input int limit);
        int n = 0;
        while ((q[0].size() > 0 || q[1].size() > 0 || v[0] || v[1] || cyc <= due[0] || cyc <= due[1]) && n < limit) begin
            step();
            n++;
        end
        chk("drain_timeout", 32'(n < limit), 32'd1);
    endtask

    task automatic push(input int p, input logic w, input logic [7:0] a, input logic [7:0] d);
        req_t r;
        r.w = w;
        r.a = a;
        r.d = d;
        q[p].push_back(r);
    endtask

    initial begin
        req_t r;
        int   sz;
        int   n;
        for (int i = 0; i < 2; i++) begin
            v[i] = 1'b0;
            wr[i] = 1'b0;
            ad[i] = 8'h00;
            wd[i] = 8'h00;
        end
        model_reset();
        step();
        chk_en = 1;
        step();
        reset = 1'b1;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_mem_write", 32'(mem_write), 32'd0);

        // store then load through port 0
        push(0, 1'b1, 8'h15, 8'hA5);
        drain(50);
        push(0, 1'b0, 8'h15, 8'h00);
        drain(50);
        chk("ld15_rdata", 32'(rd[0]), 32'hA5);
        chk("ld15_err", 32'(re[0]), 32'd0);

        // contention from reset: strict alternation starting with port 0
        reset = 1'b0;
        step();
        reset = 1'b1;
        log_p.delete();
        log_c.delete();
        push(0, 1'b0, 8'h15, 8'h00);
        push(0, 1'b0, 8'h15, 8'h00);
        push(1, 1'b0, 8'h20, 8'h00);
        push(1, 1'b0, 8'h20, 8'h00);
        drain(50);
        chk("cont_count", 32'(log_p.size()), 32'd4);
        for (int i = 0; i < log_p.size() && i < 4; i++) begin
            chk("cont_order", 32'(log_p[i]), 32'(i % 2));
            if (i > 0) chk("cont_spacing", 32'(log_c[i] - log_c[i-1]), 32'd3);
        end

        // out-of-range store leaves memory untouched
        push(0, 1'b1, 8'h00, 8'h5A);
        drain(50);
        push(1, 1'b1, 8'h80, 8'hFF);
        drain(50);
        chk("oor_err", 32'(re[1]), 32'd1);
        chk("oor_rdata", 32'(rd[1]), 32'h00);
        push(1, 1'b0, 8'h00, 8'h00);
        drain(50);
        chk("after_oor_rdata", 32'(rd[1]), 32'h5A);
        chk("after_oor_err", 32'(re[1]), 32'd0);

        // boundary addresses
        push(0, 1'b1, 8'h7F, 8'h3C);
        push(0, 1'b0, 8'h7F, 8'h00);
        drain(50);
        chk("b7f_rdata", 32'(rd[0]), 32'h3C);
        chk("b7f_err", 32'(re[0]), 32'd0);
        push(1, 1'b0, 8'hFF, 8'h00);
        drain(50);
        chk("bff_err", 32'(re[1]), 32'd1);
        chk("bff_rdata", 32'(rd[1]), 32'h00);

        // reset sampled during ISSUE of a store
        push(0, 1'b1, 8'h30, 8'h77);
        sz = log_p.size();
        n = 0;
        while (log_p.size() == sz && n < 20) begin
            step();
            n++;
        end
        chk("mid_accept_timeout", 32'(n < 20), 32'd1);
        chk("mid_issue_write", 32'(mem_write), 32'd1);
        reset = 1'b0;
        step();
        chk("mid_mem_write", 32'(mem_write), 32'd0);
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_rsp_valid", 32'(rv[0]), 32'd0);
        reset = 1'b1;
        log_p.delete();
        log_c.delete();
        push(0, 1'b0, 8'h30, 8'h00);
        push(1, 1'b0, 8'h7F, 8'h00);
        drain(50);
        chk("post_reset_first", 32'(log_p.size() > 0 ? log_p[0] : -1), 32'd0);

        // back-to-back on port 0
        log_p.delete();
        log_c.delete();
        push(0, 1'b1, 8'h40, 8'h11);
        push(0, 1'b0, 8'h40, 8'h00);
        push(0, 1'b0, 8'h30, 8'h00);
        drain(50);
        chk("b2b_count", 32'(log_c.size()), 32'd3);
        for (int i = 1; i < log_c.size(); i++)
            chk("b2b_spacing", 32'(log_c[i] - log_c[i-1]), 32'd3);
        chk("b2b_last_rdata", 32'(rd[0]), 32'h77);

        // randomized traffic with idle gaps and dropped requests
        gap_en = 1;
        for (int i = 0; i < 300; i++) begin
            r.w = 1'($urandom_range(1, 0));
            r.a = ($urandom_range(3, 0) == 0) ? 8'($urandom) : {1'b0, 7'($urandom)};
            r.d = 8'($urandom);
            q[$urandom_range(1, 0)].push_back(r);
        end
        drain(10000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
